// File: rtl/regfile_2r1w_clr.sv
// Register file with one write port, two registered read ports and a sequential clear engine.
// Optional write-to-read bypass and optional hardwired-zero entry 0.
module regfile_2r1w_clr #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter bit          BYPASS     = 1'b1,
    parameter bit          ZERO_REG   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    output logic                  o_busy,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en_a,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr_a,
    output logic [DATA_WIDTH-1:0] o_rd_data_a,
    output logic                  o_rd_vld_a,
    input  logic                  i_rd_en_b,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr_b,
    output logic [DATA_WIDTH-1:0] o_rd_data_b,
    output logic                  o_rd_vld_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        StClear,
        StReady
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clr_ptr_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] rd_data_a_q;
    logic [DATA_WIDTH-1:0] rd_data_b_q;
    logic                  rd_vld_a_q;
    logic                  rd_vld_b_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready;
    logic                  wr_fire;
    logic                  wr_commit;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_word_a;
    logic [DATA_WIDTH-1:0] rd_word_b;

    assign ready = (state_q == StReady);

    // A clear request in the same cycle drops the write and suppresses the bypass.
    assign wr_fire   = ready & i_wr_en & ~i_clear;
    assign wr_commit = wr_fire & ~(ZERO_REG && (i_wr_addr == '0));

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        if (rst_n) begin
            if (ready) begin
                mem_we    = wr_commit;
                mem_waddr = i_wr_addr;
                mem_wdata = i_wr_data;
            end else begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_word_a = mem[i_rd_addr_a];
        if (ZERO_REG && (i_rd_addr_a == '0)) begin
            rd_word_a = '0;
        end else if (BYPASS && wr_fire && (i_wr_addr == i_rd_addr_a)) begin
            rd_word_a = i_wr_data;
        end
    end

    always_comb begin
        rd_word_b = mem[i_rd_addr_b];
        if (ZERO_REG && (i_rd_addr_b == '0)) begin
            rd_word_b = '0;
        end else if (BYPASS && wr_fire && (i_wr_addr == i_rd_addr_b)) begin
            rd_word_b = i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StClear;
            clr_ptr_q   <= '0;
            busy_q      <= 1'b1;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_vld_a_q  <= 1'b0;
            rd_vld_b_q  <= 1'b0;
        end else begin
            rd_vld_a_q <= 1'b0;
            rd_vld_b_q <= 1'b0;
            unique case (state_q)
                StClear: begin
                    clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
                    if (clr_ptr_q == '1) begin
                        state_q <= StReady;
                        busy_q  <= 1'b0;
                    end
                end
                StReady: begin
                    if (i_rd_en_a) begin
                        rd_data_a_q <= rd_word_a;
                        rd_vld_a_q  <= 1'b1;
                    end
                    if (i_rd_en_b) begin
                        rd_data_b_q <= rd_word_b;
                        rd_vld_b_q  <= 1'b1;
                    end
                    if (i_clear) begin
                        state_q   <= StClear;
                        clr_ptr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_busy      = busy_q;
    assign o_rd_data_a = rd_data_a_q;
    assign o_rd_vld_a  = rd_vld_a_q;
    assign o_rd_data_b = rd_data_b_q;
    assign o_rd_vld_b  = rd_vld_b_q;

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Randomised self-checking bench for regfile_2r1w_clr against an array-based reference model.
module tb_regfile_2r1w_clr;
    parameter bit BYPASS   = 1'b1;
    parameter bit ZERO_REG = 1'b0;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en_a, rd_en_b;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_vld_a, rd_vld_b;

    regfile_2r1w_clr #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BYPASS    (BYPASS),
        .ZERO_REG  (ZERO_REG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (clear),
        .o_busy     (busy),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_rd_en_a  (rd_en_a),
        .i_rd_addr_a(rd_addr_a),
        .o_rd_data_a(rd_data_a),
        .o_rd_vld_a (rd_vld_a),
        .i_rd_en_b  (rd_en_b),
        .i_rd_addr_b(rd_addr_b),
        .o_rd_data_b(rd_data_b),
        .o_rd_vld_b (rd_vld_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    // Reference model: storage array plus count of sweep cycles still to run.
    logic [DW-1:0] mmem [DEPTH];
    int            busy_left = 0;
    logic          exp_busy = 1'b1;
    logic [DW-1:0] exp_a = '0, exp_b = '0;
    logic          exp_va = 1'b0, exp_vb = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit wr_eff);
        if (ZERO_REG && a == 0) return '0;
        if (BYPASS && wr_eff && wr_addr == a) return wr_data;
        return mmem[a];
    endfunction

    task automatic model_step();
        bit wr_eff;
        if (!rst_n) begin
            busy_left = DEPTH;
            exp_a = '0; exp_b = '0; exp_va = 1'b0; exp_vb = 1'b0;
        end else if (busy_left > 0) begin
            mmem[DEPTH - busy_left] = '0;
            busy_left--;
            exp_va = 1'b0; exp_vb = 1'b0;
        end else begin
            wr_eff = wr_en && !clear;
            if (rd_en_a) exp_a = model_read(rd_addr_a, wr_eff);
            if (rd_en_b) exp_b = model_read(rd_addr_b, wr_eff);
            exp_va = rd_en_a;
            exp_vb = rd_en_b;
            if (clear) busy_left = DEPTH;
            else if (wr_en && !(ZERO_REG && wr_addr == 0)) mmem[wr_addr] = wr_data;
        end
        exp_busy = (busy_left > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("vld_a", 32'(rd_vld_a), 32'(exp_va));
            chk("vld_b", 32'(rd_vld_b), 32'(exp_vb));
            chk("data_a", 32'(rd_data_a), 32'(exp_a));
            chk("data_b", 32'(rd_data_b), 32'(exp_b));
        end
    end

    task automatic set_io(input bit we, input int wa, input int wd, input bit ea, input int ra,
                          input bit eb, input int rb, input bit clr);
        wr_en = we; wr_addr = AW'(wa); wr_data = DW'(wd);
        rd_en_a = ea; rd_addr_a = AW'(ra);
        rd_en_b = eb; rd_addr_b = AW'(rb);
        clear = clr;
    endtask

    task automatic idle();
        set_io(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_io(input bit allow_clear);
        int wa;
        wa = int'($urandom_range(0, DEPTH - 1));
        set_io($urandom_range(0, 1) == 1, wa, int'($urandom_range(0, 16'hFFFF)),
               $urandom_range(0, 1) == 1,
               ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, DEPTH - 1)),
               $urandom_range(0, 1) == 1,
               ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, DEPTH - 1)),
               allow_clear && ($urandom_range(0, 59) == 0));
    endtask

    // Counts cycles with busy high, starting from the current one.
    task automatic count_busy(output int cnt, input bit rand_traffic);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (rand_traffic) rand_io(1'b1);
            else set_io(0, 0, 0, 1, 2, 1, 9, 0);
            tick();
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        for (int i = 0; i < DEPTH; i++) mmem[i] = DW'($urandom);
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        check_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_vld_a", 32'(rd_vld_a), 32'd0);
        chk("rst_data_b", 32'(rd_data_b), 32'd0);

        // Initial sweep and all-zero readback.
        rst_n = 1'b1;
        count_busy(cnt, 1'b0);
        chk("init_busy_cycles", 32'(cnt), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            set_io(0, 0, 0, 1, i, 1, DEPTH - 1 - i, 0);
            tick();
            chk("init_zero_a", 32'(rd_data_a), 32'h0);
            chk("init_vld_b", 32'(rd_vld_b), 32'd1);
        end

        // Basic write then read.
        set_io(1, 3, 16'hA5A5, 0, 0, 0, 0, 0); tick();
        set_io(0, 0, 0, 1, 3, 0, 0, 0); tick();
        chk("wr_rd_data", 32'(rd_data_a), 32'hA5A5);
        chk("wr_rd_vld", 32'(rd_vld_a), 32'd1);
        idle(); tick();
        chk("vld_pulse", 32'(rd_vld_a), 32'd0);
        chk("data_hold", 32'(rd_data_a), 32'hA5A5);

        // Same-cycle write/read collision.
        set_io(1, 5, 16'h1111, 0, 0, 0, 0, 0); tick();
        set_io(1, 5, 16'h1234, 0, 0, 1, 5, 0); tick();
        chk("bypass_b", 32'(rd_data_b), BYPASS ? 32'h1234 : 32'h1111);
        set_io(0, 0, 0, 0, 0, 1, 5, 0); tick();
        chk("after_bypass_b", 32'(rd_data_b), 32'h1234);

        // Entry 0 behaviour.
        set_io(1, 0, 16'hFFFF, 0, 0, 0, 0, 0); tick();
        set_io(0, 0, 0, 1, 0, 1, 0, 0); tick();
        chk("zero_a", 32'(rd_data_a), ZERO_REG ? 32'h0 : 32'hFFFF);
        chk("zero_b", 32'(rd_data_b), ZERO_REG ? 32'h0 : 32'hFFFF);

        // Fill, then clear together with a write; read in that cycle sees pre-clear data.
        for (int i = 0; i < DEPTH; i++) begin
            set_io(1, i, 16'h1000 + i, 0, 0, 0, 0, 0); tick();
        end
        set_io(1, 7, 16'hBEEF, 1, 7, 0, 0, 1); tick();
        chk("clear_read_a", 32'(rd_data_a), 32'h1007);
        chk("clear_busy", 32'(busy), 32'd1);
        count_busy(cnt, 1'b1);
        chk("clear_busy_cycles", 32'(cnt), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            set_io(0, 0, 0, 1, i, 1, i, 0); tick();
            chk("cleared_a", 32'(rd_data_a), 32'h0);
        end

        // Reset in the middle of a sweep restarts it.
        set_io(0, 0, 0, 0, 0, 0, 0, 1); tick();
        idle();
        for (int i = 0; i < 8; i++) tick();
        rst_n = 1'b0; set_io(0, 0, 0, 1, 1, 1, 1, 0); tick();
        rst_n = 1'b1; tick();
        chk("midrst_vld", 32'(rd_vld_a), 32'd0);
        count_busy(cnt, 1'b0);
        chk("midrst_busy_cycles", 32'(cnt), 32'd15);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 1500; i++) begin
            rand_io(1'b1);
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
